// File: rtl/bist_sequencer_pkg.sv
// Shared definitions for the memory BIST sequencer.
//   - state_t          : sequencer FSM states
//   - DEFAULT_PAT0/1   : checkerboard backgrounds for pass 0 and pass 1
//   - ERR_CODE_W       : width of the error code sent to the BIST output buffer
//   - MAX_ADDR_W       : widest RAM address that still fits the 7-bit address
//                        field of the error code
//   - replicate_pat()  : widens an 8-bit background so it can be cut to any
//                        data width up to 64 bits
package bist_sequencer_pkg;

  localparam int ERR_CODE_W = 8;
  localparam int MAX_ADDR_W = 7;
  localparam int MAX_DATA_W = 64;

  localparam logic [7:0] DEFAULT_PAT0 = 8'h55;
  localparam logic [7:0] DEFAULT_PAT1 = 8'hAA;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_CMP,
    S_DONE
  } state_t;

  // The caller truncates the result to its own data width.
  function automatic logic [MAX_DATA_W-1:0] replicate_pat(input logic [7:0] pat);
    return {(MAX_DATA_W/8){pat}};
  endfunction

endpackage

// File: rtl/bist_sequencer_if.sv
// RAM-side bus of the BIST sequencer.
//   mem_addr  : word address               (sequencer -> RAM)
//   mem_wdata : write data                 (sequencer -> RAM)
//   mem_we    : write enable               (sequencer -> RAM)
//   mem_re    : read enable                (sequencer -> RAM)
//   mem_rdata : read data, valid exactly one cycle after mem_re (RAM -> sequencer)
// The master modport is used by the sequencer, the slave modport by the RAM.
interface bist_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_re,
    output mem_rdata
  );

endinterface

// File: rtl/bist_sequencer_addr_cnt.sv
// Word address counter for the BIST march.
//   clk  : clock, posedge
//   res  : synchronous active-high reset, counter returns to 0
//   clr  : load 0 on the next edge (takes priority over inc)
//   inc  : advance by one on the next edge
//   addr : current address (registered)
//   last : addr is the final word (DEPTH-1)
module bist_sequencer_addr_cnt #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              res,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  assign last = (addr_q == '1);
  assign addr = addr_q;

  // Saturate at the last word instead of wrapping, so a stray inc can never
  // send the march back to address 0.
  always_comb begin
    addr_d = addr_q;
    if (clr) begin
      addr_d = '0;
    end else if (inc && !last) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/bist_sequencer.sv
// Memory BIST sequencer run behind the JTAG RUNBIST instruction.
// Performs a two-pass checkerboard march (write all words, then read and
// compare all words; pass 0 uses PAT0, pass 1 uses PAT1) and stops on the
// first mismatch.
//   clk      : clock, posedge
//   res      : synchronous active-high reset, effective from any state
//   start    : level from TAP decode, sampled only in IDLE and DONE
//   mem      : RAM bus (master side)
//   Err_code : {pass index, address zero-extended to 7 bits}
//   Err_flag : one-cycle pulse on the first mismatch of a run
//   busy     : high while writing, reading or comparing
//   done     : run finished, held until the next start
//   fail     : valid while done=1, set when a mismatch was found
module bist_sequencer
  import bist_sequencer_pkg::*;
#(
  parameter int         ADDR_W = 4,
  parameter int         DATA_W = 8,
  parameter logic [7:0] PAT0   = DEFAULT_PAT0,
  parameter logic [7:0] PAT1   = DEFAULT_PAT1
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  bist_sequencer_if.master      mem,
  output logic [ERR_CODE_W-1:0] Err_code,
  output logic                  Err_flag,
  output logic                  busy,
  output logic                  done,
  output logic                  fail
);

  // The error code only has room for a 7-bit address.
  generate
    if (ADDR_W < 1 || ADDR_W > MAX_ADDR_W) begin : g_bad_addr_w
      $error("bist_sequencer: ADDR_W must be in 1..7");
    end
    if (DATA_W < 1 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
      $error("bist_sequencer: DATA_W must be in 1..64");
    end
  endgenerate

  localparam logic [DATA_W-1:0] PAT0_X = DATA_W'(replicate_pat(PAT0));
  localparam logic [DATA_W-1:0] PAT1_X = DATA_W'(replicate_pat(PAT1));

  state_t                state_q, state_d;
  logic                  pass_q, pass_d;
  logic                  fail_q, fail_d;
  logic [ERR_CODE_W-1:0] err_code_q, err_code_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_re_q, mem_re_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;

  logic                  cnt_clr;
  logic                  cnt_inc;
  logic [ADDR_W-1:0]     addr;
  logic                  addr_last;

  logic [DATA_W-1:0]     exp_pat;
  logic                  mismatch;
  logic [ERR_CODE_W-1:0] cur_code;

  bist_sequencer_addr_cnt #(
    .ADDR_W (ADDR_W)
  ) u_addr_cnt (
    .clk  (clk),
    .res  (res),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .addr (addr),
    .last (addr_last)
  );

  assign exp_pat  = pass_q ? PAT1_X : PAT0_X;
  assign mismatch = (mem.mem_rdata != exp_pat);
  assign cur_code = {pass_q, 7'(addr)};

  // State register, including the registered outputs.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= S_IDLE;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      err_code_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state logic: march sequencing, address stepping and result capture.
  // A (re)start from IDLE or DONE wipes the previous verdict and error code.
  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    err_code_d = err_code_q;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_WR;
          pass_d     = 1'b0;
          fail_d     = 1'b0;
          err_code_d = '0;
          cnt_clr    = 1'b1;
        end
      end
      S_WR: begin
        if (addr_last) begin
          state_d = S_RD;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_RD: begin
        state_d = S_CMP;
      end
      S_CMP: begin
        if (mismatch) begin
          state_d    = S_DONE;
          fail_d     = 1'b1;
          err_code_d = cur_code;
        end else if (!addr_last) begin
          state_d = S_RD;
          cnt_inc = 1'b1;
        end else if (!pass_q) begin
          state_d = S_WR;
          pass_d  = 1'b1;
          cnt_clr = 1'b1;
        end else begin
          state_d = S_DONE;
          fail_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic: decoded from the next state so each registered output lines
  // up with the state it belongs to.
  always_comb begin
    busy_d      = (state_d == S_WR) || (state_d == S_RD) || (state_d == S_CMP);
    done_d      = (state_d == S_DONE);
    mem_we_d    = (state_d == S_WR);
    mem_re_d    = (state_d == S_RD);
    mem_wdata_d = '0;
    if (state_d == S_WR) begin
      mem_wdata_d = pass_d ? PAT1_X : PAT0_X;
    end
  end

  // The error pulse comes straight from the compare in the CMP cycle itself,
  // so it never overlaps done, and the output buffer sees the matching code
  // in the same cycle. Reset suppresses it so an aborted run reports nothing.
  assign Err_flag = (state_q == S_CMP) && mismatch && !res;
  assign Err_code = Err_flag ? cur_code : err_code_q;

  assign busy = busy_q;
  assign done = done_q;
  assign fail = fail_q;

  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_re    = mem_re_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Self-checking bench for bist_sequencer with ADDR_W=4, DATA_W=8.
// A behavioural RAM with an injectable stuck-at fault answers the sequencer;
// every run pushes its expected writes and its expected outcome into
// scoreboard queues, which are drained as the DUT produces them.
module tb_bist_sequencer;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic       clk;
  logic       res;
  logic       start;
  logic [7:0] err_code;
  logic       err_flag;
  logic       busy;
  logic       done;
  logic       fail;

  int total = 0;
  int bad   = 0;

  bist_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  bist_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk      (clk),
    .res      (res),
    .start    (start),
    .mem      (mem_if),
    .Err_code (err_code),
    .Err_flag (err_flag),
    .busy     (busy),
    .done     (done),
    .fail     (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM; the fault is applied on the read path of one word.
  logic [DATA_W-1:0] ram [DEPTH];
  logic              fault_en;
  logic [ADDR_W-1:0] fault_addr;
  logic [DATA_W-1:0] sa0_mask;
  logic [DATA_W-1:0] sa1_mask;

  always @(posedge clk) begin
    if (mem_if.mem_we) ram[mem_if.mem_addr] <= mem_if.mem_wdata;
    if (mem_if.mem_re) begin
      if (fault_en && mem_if.mem_addr == fault_addr)
        mem_if.mem_rdata <= (ram[mem_if.mem_addr] & ~sa0_mask) | sa1_mask;
      else
        mem_if.mem_rdata <= ram[mem_if.mem_addr];
    end
  end

  typedef struct {
    int         busy_cycles;
    logic       fail;
    logic [7:0] code;
    int         flags;
  } run_exp_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_exp_t;

  run_exp_t exp_q[$];
  wr_exp_t  wr_q[$];

  task automatic push_pass_writes(input logic p);
    wr_exp_t w;
    for (int i = 0; i < DEPTH; i++) begin
      w.addr = ADDR_W'(i);
      w.data = p ? 8'hAA : 8'h55;
      wr_q.push_back(w);
    end
  endtask

  task automatic push_run(input int bc, input logic f, input logic [7:0] c, input int fl);
    run_exp_t e;
    e.busy_cycles = bc;
    e.fail        = f;
    e.code        = c;
    e.flags       = fl;
    exp_q.push_back(e);
  endtask

  task automatic set_fault(input logic en, input logic [3:0] a, input logic [7:0] m0, input logic [7:0] m1);
    fault_en   = en;
    fault_addr = a;
    sa0_mask   = m0;
    sa1_mask   = m1;
  endtask

  // Follows one run from the cycle after start was sampled until done rises,
  // draining the write scoreboard as writes appear and the run scoreboard at done.
  task automatic monitor_run(input string name, input bit drop_start);
    int         cyc;
    int         busy_cnt;
    int         flag_cnt;
    logic [7:0] flag_code;
    bit         finished;
    run_exp_t   e;
    wr_exp_t    w;
    cyc = 0; busy_cnt = 0; flag_cnt = 0; flag_code = 8'h00; finished = 0;
    while (!finished && cyc < 1000) begin
      @(negedge clk);
      if (drop_start) start = 1'b0;
      cyc++;
      if (cyc == 1) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("[TB] FAIL %s start_latency: busy=%0b expected 1", name, busy);
        end
      end
      if (busy) busy_cnt++;
      if (mem_if.mem_we) begin
        total++;
        if (wr_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL %s unexpected_write: addr=%0d data=%h", name, mem_if.mem_addr, mem_if.mem_wdata);
        end else begin
          w = wr_q.pop_front();
          if (mem_if.mem_addr !== w.addr || mem_if.mem_wdata !== w.data) begin
            bad++;
            $display("[TB] FAIL %s write: addr=%0d data=%h expected addr=%0d data=%h",
                     name, mem_if.mem_addr, mem_if.mem_wdata, w.addr, w.data);
          end
        end
      end
      if (err_flag) begin
        flag_cnt++;
        flag_code = err_code;
        total++;
        if (done !== 1'b0) begin
          bad++;
          $display("[TB] FAIL %s flag_with_done: done=%0b expected 0", name, done);
        end
      end
      if (done) finished = 1;
    end
    if (!finished) begin
      total++; bad++;
      $display("[TB] FAIL %s timeout: done never rose within %0d cycles", name, cyc);
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s scoreboard: no expected run queued", name);
    end else begin
      e = exp_q.pop_front();
      if (busy_cnt !== e.busy_cycles) begin
        bad++;
        $display("[TB] FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, e.busy_cycles);
      end
      total++;
      if (flag_cnt !== e.flags) begin
        bad++;
        $display("[TB] FAIL %s flag_count: got %0d expected %0d", name, flag_cnt, e.flags);
      end
      total++;
      if (fail !== e.fail || busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL %s verdict: fail=%0b busy=%0b expected fail=%0b busy=0", name, fail, busy, e.fail);
      end
      total++;
      if (err_code !== e.code) begin
        bad++;
        $display("[TB] FAIL %s err_code_held: got %h expected %h", name, err_code, e.code);
      end
      if (e.flags > 0) begin
        total++;
        if (flag_code !== e.code) begin
          bad++;
          $display("[TB] FAIL %s err_code_at_flag: got %h expected %h", name, flag_code, e.code);
        end
      end
    end
    total++;
    if (wr_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s missing_writes: %0d writes never seen", name, wr_q.size());
      wr_q.delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0 || err_flag !== 1'b0 || err_code !== 8'h00) begin
      bad++;
      $display("[TB] FAIL %s status_zero: busy=%0b done=%0b fail=%0b flag=%0b code=%h expected all 0",
               name, busy, done, fail, err_flag, err_code);
    end
    total++;
    if (mem_if.mem_we !== 1'b0 || mem_if.mem_re !== 1'b0 || mem_if.mem_addr !== 4'h0 || mem_if.mem_wdata !== 8'h00) begin
      bad++;
      $display("[TB] FAIL %s mem_zero: we=%0b re=%0b addr=%0d wdata=%h expected all 0",
               name, mem_if.mem_we, mem_if.mem_re, mem_if.mem_addr, mem_if.mem_wdata);
    end
  endtask

  task automatic test_reset();
    res = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    res = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_no_start: busy=%0b done=%0b expected 0 0", busy, done);
    end
  endtask

  task automatic test_clean_run(input string name);
    set_fault(1'b0, 4'h0, 8'h00, 8'h00);
    push_pass_writes(1'b0);
    push_pass_writes(1'b1);
    push_run(96, 1'b0, 8'h00, 0);
    @(negedge clk); start = 1'b1;
    monitor_run(name, 1'b1);
  endtask

  // Bit 2 stuck-at-0: 0x55 has bit 2 set, so the first compare of addr 5 fails.
  task automatic test_pass0_fault();
    set_fault(1'b1, 4'h5, 8'h04, 8'h00);
    push_pass_writes(1'b0);
    push_run(28, 1'b1, 8'h05, 1);
    @(negedge clk); start = 1'b1;
    monitor_run("pass0_fault", 1'b1);
  endtask

  // Bit 0 stuck-at-1: harmless for 0x55, caught against 0xAA.
  task automatic test_pass1_fault();
    set_fault(1'b1, 4'h5, 8'h00, 8'h01);
    push_pass_writes(1'b0);
    push_pass_writes(1'b1);
    push_run(76, 1'b1, 8'h85, 1);
    @(negedge clk); start = 1'b1;
    monitor_run("pass1_fault", 1'b1);
  endtask

  // Bit 1 stuck-at-0 on the last word: only the final compare of pass 1 fails.
  task automatic test_last_word_fault();
    set_fault(1'b1, 4'hF, 8'h02, 8'h00);
    push_pass_writes(1'b0);
    push_pass_writes(1'b1);
    push_run(96, 1'b1, 8'h8F, 1);
    @(negedge clk); start = 1'b1;
    monitor_run("last_word_fault", 1'b1);
    repeat (4) @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || fail !== 1'b1 || err_code !== 8'h8F) begin
      bad++;
      $display("[TB] FAIL last_word_hold: done=%0b busy=%0b fail=%0b code=%h expected 1 0 1 8f",
               done, busy, fail, err_code);
    end
  endtask

  task automatic test_reset_mid_wr();
    int k;
    set_fault(1'b0, 4'h0, 8'h00, 8'h00);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!(mem_if.mem_we && mem_if.mem_addr == 4'h9) && k < 100) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k >= 100) begin
      bad++;
      $display("[TB] FAIL reset_mid_wr_reach: addr 9 write not seen, addr=%0d", mem_if.mem_addr);
    end
    res = 1'b1;
    @(negedge clk);
    check_all_zero("reset_mid_wr");
    res = 1'b0;
    test_clean_run("after_reset_run");
  endtask

  task automatic test_reset_in_cmp();
    int k;
    set_fault(1'b1, 4'h5, 8'h04, 8'h00);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!(mem_if.mem_re && mem_if.mem_addr == 4'h5) && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    res = 1'b1;
    #1;
    total++;
    if (err_flag !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_in_cmp_flag: Err_flag=%0b expected 0", err_flag);
    end
    @(negedge clk);
    check_all_zero("reset_in_cmp");
    res = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_fault(1'b1, 4'h5, 8'h04, 8'h00);
    push_pass_writes(1'b0);
    push_run(28, 1'b1, 8'h05, 1);
    @(negedge clk); start = 1'b1;
    monitor_run("hold_start", 1'b0);
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || fail !== 1'b0 || err_code !== 8'h00 || mem_if.mem_we !== 1'b1) begin
      bad++;
      $display("[TB] FAIL restart: busy=%0b done=%0b fail=%0b code=%h we=%0b expected 1 0 0 00 1",
               busy, done, fail, err_code, mem_if.mem_we);
    end
    start = 1'b0;
    res = 1'b1;
    @(negedge clk);
    check_all_zero("restart_abort");
    res = 1'b0;
  endtask

  initial begin
    res = 1'b1;
    start = 1'b0;
    set_fault(1'b0, 4'h0, 8'h00, 8'h00);
    test_reset();
    test_clean_run("clean_run");
    test_pass0_fault();
    test_pass1_fault();
    test_last_word_fault();
    test_reset_mid_wr();
    test_reset_in_cmp();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
